// File: rtl/score_keeper.sv
// Purpose: Pong game-flow controller; owns both scores and sequences idle -> serve -> play -> point -> game over.
// Latency: every output is registered and reflects its triggering input one clock later.
// Backpressure: none; frame_tick and point pulses are consumed the cycle they arrive or dropped.
//
// Ports:
//   clock, reset_n           : clock, async active-low reset (release expected synchronous to clock)
//   frame_tick               : one-cycle pulse per video frame; paces serve delay and blink
//   start                    : debounced start button level; only its rising edge acts
//   point_p1, point_p2       : one-cycle pulses from the ball logic when a player scores
//   score_p1, score_p2       : 0..WIN_SCORE, fed straight to the digit ROM
//   ball_enable, serve_dir   : ball may move / serve toward p1 (0) or p2 (1)
//   game_over, winner, blink : end-of-game flag, winning player (0=p1, 1=p2), score flash
module score_keeper #(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_DELAY  = 60,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       point_p1,
  input  logic       point_p2,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       ball_enable,
  output logic       serve_dir,
  output logic       game_over,
  output logic       winner,
  output logic       blink
);

  // One counter is shared: serve delay in SERVE, blink pacing in GAME_OVER.
  localparam int CNT_MAX = (SERVE_DELAY > BLINK_FRAMES) ? SERVE_DELAY : BLINK_FRAMES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SERVE_LOAD = CW'(SERVE_DELAY);
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_FRAMES - 1);
  localparam logic [3:0]    WIN_VAL    = 4'(WIN_SCORE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SERVE,
    S_PLAY,
    S_GAME_OVER
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    score_p1_nxt, score_p2_nxt;
  logic          serve_dir_nxt, winner_nxt, blink_nxt;
  logic          start_q;
  logic          armed;
  logic          start_rise;
  logic          p1_only, p2_only, p_both;
  logic          p1_wins, p2_wins;

  // start_q clears in reset, so a button held through reset would look like an
  // edge on the first clock after release; armed masks that first cycle.
  assign start_rise = start & ~start_q & armed;

  assign p1_only = point_p1 & ~point_p2;
  assign p2_only = point_p2 & ~point_p1;
  assign p_both  = point_p1 & point_p2;
  assign p1_wins = (score_p1 + 4'd1) == WIN_VAL;
  assign p2_wins = (score_p2 + 4'd1) == WIN_VAL;

  // State register and all output/datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      start_q     <= 1'b0;
      armed       <= 1'b0;
      score_p1    <= 4'd0;
      score_p2    <= 4'd0;
      ball_enable <= 1'b0;
      serve_dir   <= 1'b0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
      blink       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      start_q     <= start;
      armed       <= 1'b1;
      score_p1    <= score_p1_nxt;
      score_p2    <= score_p2_nxt;
      ball_enable <= (state_nxt == S_PLAY);
      serve_dir   <= serve_dir_nxt;
      game_over   <= (state_nxt == S_GAME_OVER);
      winner      <= winner_nxt;
      blink       <= blink_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start_rise) state_nxt = S_SERVE;
      S_SERVE:     if (cnt == '0) state_nxt = S_PLAY;
      S_PLAY: begin
        if (p_both)                    state_nxt = S_SERVE;
        else if (p1_only)              state_nxt = p1_wins ? S_GAME_OVER : S_SERVE;
        else if (p2_only)              state_nxt = p2_wins ? S_GAME_OVER : S_SERVE;
      end
      S_GAME_OVER: if (start_rise) state_nxt = S_SERVE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Next values for scores, counter, serve direction, winner and blink.
  always_comb begin
    cnt_nxt       = cnt;
    score_p1_nxt  = score_p1;
    score_p2_nxt  = score_p2;
    serve_dir_nxt = serve_dir;
    winner_nxt    = winner;
    blink_nxt     = blink;
    case (state)
      S_IDLE: begin
        if (start_rise) begin
          score_p1_nxt = 4'd0;
          score_p2_nxt = 4'd0;
          cnt_nxt      = SERVE_LOAD;
        end
      end
      S_SERVE: begin
        if (frame_tick && cnt != '0) cnt_nxt = cnt - CW'(1);
      end
      S_PLAY: begin
        if (p_both) begin
          // Simultaneous points: replay the rally, nothing else changes.
          cnt_nxt = SERVE_LOAD;
        end else if (p1_only) begin
          score_p1_nxt  = score_p1 + 4'd1;
          serve_dir_nxt = 1'b1;
          if (p1_wins) begin
            winner_nxt = 1'b0;
            cnt_nxt    = '0;
          end else begin
            cnt_nxt    = SERVE_LOAD;
          end
        end else if (p2_only) begin
          score_p2_nxt  = score_p2 + 4'd1;
          serve_dir_nxt = 1'b0;
          if (p2_wins) begin
            winner_nxt = 1'b1;
            cnt_nxt    = '0;
          end else begin
            cnt_nxt    = SERVE_LOAD;
          end
        end
      end
      S_GAME_OVER: begin
        if (start_rise) begin
          score_p1_nxt = 4'd0;
          score_p2_nxt = 4'd0;
          blink_nxt    = 1'b0;
          cnt_nxt      = SERVE_LOAD;
        end else if (frame_tick) begin
          if (cnt == BLINK_LAST) begin
            cnt_nxt   = '0;
            blink_nxt = ~blink;
          end else begin
            cnt_nxt   = cnt + CW'(1);
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

  logic       clock      = 1'b0;
  logic       reset_n    = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start      = 1'b0;
  logic       point_p1   = 1'b0;
  logic       point_p2   = 1'b0;

  logic [3:0] score_p1, score_p2;
  logic       ball_enable, serve_dir, game_over, winner, blink;
  logic [3:0] d0_score_p1, d0_score_p2;
  logic       d0_ball_enable, d0_serve_dir, d0_game_over, d0_winner, d0_blink;

  always #5 clock = ~clock;

  score_keeper #(.WIN_SCORE(3), .SERVE_DELAY(2), .BLINK_FRAMES(2)) dut (
    .clock(clock), .reset_n(reset_n), .frame_tick(frame_tick), .start(start),
    .point_p1(point_p1), .point_p2(point_p2),
    .score_p1(score_p1), .score_p2(score_p2), .ball_enable(ball_enable),
    .serve_dir(serve_dir), .game_over(game_over), .winner(winner), .blink(blink)
  );

  score_keeper #(.WIN_SCORE(3), .SERVE_DELAY(0), .BLINK_FRAMES(2)) dut0 (
    .clock(clock), .reset_n(reset_n), .frame_tick(frame_tick), .start(start),
    .point_p1(point_p1), .point_p2(point_p2),
    .score_p1(d0_score_p1), .score_p2(d0_score_p2), .ball_enable(d0_ball_enable),
    .serve_dir(d0_serve_dir), .game_over(d0_game_over), .winner(d0_winner), .blink(d0_blink)
  );

  typedef struct packed {
    logic [3:0] s1;
    logic [3:0] s2;
    logic       be;
    logic       sd;
    logic       go;
    logic       wn;
    logic       bl;
  } out_t;

  typedef struct packed {
    logic st;
    logic ft;
    logic p1;
    logic p2;
  } stim_t;

  out_t  sb[$];       // expected outputs, pushed as stimulus is driven
  stim_t pend_s[$];   // stimulus rows of the current scenario
  out_t  pend_e[$];   // matching expected outputs
  int    n_cmp  = 0;
  int    n_fail = 0;

  function automatic out_t mk(input int s1, input int s2, input bit be, input bit sd,
                              input bit go, input bit wn, input bit bl);
    out_t o;
    o.s1 = 4'(s1); o.s2 = 4'(s2);
    o.be = be; o.sd = sd; o.go = go; o.wn = wn; o.bl = bl;
    return o;
  endfunction

  function automatic stim_t stim(input bit st, input bit ft, input bit p1, input bit p2);
    stim_t s;
    s.st = st; s.ft = ft; s.p1 = p1; s.p2 = p2;
    return s;
  endfunction

  function automatic out_t observe();
    out_t o;
    o.s1 = score_p1; o.s2 = score_p2; o.be = ball_enable; o.sd = serve_dir;
    o.go = game_over; o.wn = winner; o.bl = blink;
    return o;
  endfunction

  function automatic out_t observe0();
    out_t o;
    o.s1 = d0_score_p1; o.s2 = d0_score_p2; o.be = d0_ball_enable; o.sd = d0_serve_dir;
    o.go = d0_game_over; o.wn = d0_winner; o.bl = d0_blink;
    return o;
  endfunction

  function automatic string fmt(input out_t o);
    return $sformatf("s1=%0d s2=%0d be=%b sd=%b go=%b wn=%b bl=%b",
                     o.s1, o.s2, o.be, o.sd, o.go, o.wn, o.bl);
  endfunction

  task automatic add(input stim_t s, input out_t e);
    pend_s.push_back(s);
    pend_e.push_back(e);
  endtask

  task automatic apply(input stim_t s);
    start = s.st; frame_tick = s.ft; point_p1 = s.p1; point_p2 = s.p2;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Held start through reset release must not count as an edge.
  task automatic test_reset();
    out_t got, want;
    int   i = 0;
    reset_n = 1'b0;
    apply(stim(1, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    cyc(); cyc();
    got = observe(); want = sb.pop_front(); n_cmp++;
    if (got !== want) begin
      n_fail++; $display("FAIL reset_hold: got %s, expected %s", fmt(got), fmt(want));
    end
    #3 reset_n = 1'b1;
    repeat (3) add(stim(1, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0));
    add(stim(0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0));
    while (pend_s.size() != 0) begin
      apply(pend_s.pop_front()); sb.push_back(pend_e.pop_front()); cyc();
      got = observe(); want = sb.pop_front(); n_cmp++;
      if (got !== want) begin
        n_fail++; $display("FAIL reset_release[%0d]: got %s, expected %s", i, fmt(got), fmt(want));
      end
      i++;
    end
  endtask

  // Start edge, serve delay of 2 ticks, points ignored while serving, start ignored in play.
  task automatic test_serve();
    out_t got, want;
    int   i = 0;
    add(stim(1, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0));
    add(stim(0, 1, 1, 0), mk(0, 0, 0, 0, 0, 0, 0));
    add(stim(0, 1, 0, 1), mk(0, 0, 0, 0, 0, 0, 0));
    add(stim(0, 1, 0, 0), mk(0, 0, 1, 0, 0, 0, 0));
    add(stim(0, 0, 0, 0), mk(0, 0, 1, 0, 0, 0, 0));
    add(stim(1, 0, 0, 0), mk(0, 0, 1, 0, 0, 0, 0));
    add(stim(0, 0, 0, 0), mk(0, 0, 1, 0, 0, 0, 0));
    while (pend_s.size() != 0) begin
      apply(pend_s.pop_front()); sb.push_back(pend_e.pop_front()); cyc();
      got = observe(); want = sb.pop_front(); n_cmp++;
      if (got !== want) begin
        n_fail++; $display("FAIL serve[%0d]: got %s, expected %s", i, fmt(got), fmt(want));
      end
      i++;
    end
  endtask

  task automatic test_point_p2();
    out_t got, want;
    int   i = 0;
    add(stim(0, 0, 0, 1), mk(0, 1, 0, 0, 0, 0, 0));
    add(stim(0, 0, 0, 0), mk(0, 1, 0, 0, 0, 0, 0));
    add(stim(0, 1, 0, 0), mk(0, 1, 0, 0, 0, 0, 0));
    add(stim(0, 1, 0, 0), mk(0, 1, 0, 0, 0, 0, 0));
    add(stim(0, 0, 0, 0), mk(0, 1, 1, 0, 0, 0, 0));
    while (pend_s.size() != 0) begin
      apply(pend_s.pop_front()); sb.push_back(pend_e.pop_front()); cyc();
      got = observe(); want = sb.pop_front(); n_cmp++;
      if (got !== want) begin
        n_fail++; $display("FAIL point_p2[%0d]: got %s, expected %s", i, fmt(got), fmt(want));
      end
      i++;
    end
  endtask

  // p1 scores (serve_dir -> 1), then a double point replays with nothing changed.
  task automatic test_both_points();
    out_t got, want;
    int   i = 0;
    add(stim(0, 0, 1, 0), mk(1, 1, 0, 1, 0, 0, 0));
    add(stim(1, 1, 0, 0), mk(1, 1, 0, 1, 0, 0, 0));
    add(stim(0, 1, 0, 0), mk(1, 1, 0, 1, 0, 0, 0));
    add(stim(0, 0, 0, 0), mk(1, 1, 1, 1, 0, 0, 0));
    add(stim(0, 0, 1, 1), mk(1, 1, 0, 1, 0, 0, 0));
    add(stim(0, 1, 0, 0), mk(1, 1, 0, 1, 0, 0, 0));
    add(stim(0, 1, 0, 0), mk(1, 1, 0, 1, 0, 0, 0));
    add(stim(0, 0, 0, 0), mk(1, 1, 1, 1, 0, 0, 0));
    while (pend_s.size() != 0) begin
      apply(pend_s.pop_front()); sb.push_back(pend_e.pop_front()); cyc();
      got = observe(); want = sb.pop_front(); n_cmp++;
      if (got !== want) begin
        n_fail++; $display("FAIL both_points[%0d]: got %s, expected %s", i, fmt(got), fmt(want));
      end
      i++;
    end
  endtask

  // p1 reaches 3, blink every 2 ticks, points ignored, start edge restarts.
  task automatic test_game_over();
    out_t got, want;
    int   i = 0;
    add(stim(0, 0, 1, 0), mk(2, 1, 0, 1, 0, 0, 0));
    add(stim(0, 1, 0, 0), mk(2, 1, 0, 1, 0, 0, 0));
    add(stim(0, 1, 0, 0), mk(2, 1, 0, 1, 0, 0, 0));
    add(stim(0, 0, 0, 0), mk(2, 1, 1, 1, 0, 0, 0));
    add(stim(0, 0, 1, 0), mk(3, 1, 0, 1, 1, 0, 0));
    add(stim(0, 1, 0, 0), mk(3, 1, 0, 1, 1, 0, 0));
    add(stim(0, 1, 0, 0), mk(3, 1, 0, 1, 1, 0, 1));
    add(stim(0, 0, 0, 1), mk(3, 1, 0, 1, 1, 0, 1));
    add(stim(0, 1, 0, 0), mk(3, 1, 0, 1, 1, 0, 1));
    add(stim(0, 1, 0, 0), mk(3, 1, 0, 1, 1, 0, 0));
    add(stim(0, 1, 0, 0), mk(3, 1, 0, 1, 1, 0, 0));
    add(stim(1, 0, 0, 0), mk(0, 0, 0, 1, 0, 0, 0));
    add(stim(0, 1, 0, 0), mk(0, 0, 0, 1, 0, 0, 0));
    add(stim(0, 1, 0, 0), mk(0, 0, 0, 1, 0, 0, 0));
    add(stim(0, 0, 0, 0), mk(0, 0, 1, 1, 0, 0, 0));
    while (pend_s.size() != 0) begin
      apply(pend_s.pop_front()); sb.push_back(pend_e.pop_front()); cyc();
      got = observe(); want = sb.pop_front(); n_cmp++;
      if (got !== want) begin
        n_fail++; $display("FAIL game_over[%0d]: got %s, expected %s", i, fmt(got), fmt(want));
      end
      i++;
    end
  endtask

  // p2 scores three straight rallies and wins.
  task automatic test_p2_wins();
    out_t got, want;
    int   i = 0;
    for (int k = 1; k <= 3; k++) begin
      add(stim(0, 0, 0, 1), mk(0, k, 0, 0, k == 3, k == 3, 0));
      if (k < 3) begin
        add(stim(0, 1, 0, 0), mk(0, k, 0, 0, 0, 0, 0));
        add(stim(0, 1, 0, 0), mk(0, k, 0, 0, 0, 0, 0));
        add(stim(0, 0, 0, 0), mk(0, k, 1, 0, 0, 0, 0));
      end
    end
    while (pend_s.size() != 0) begin
      apply(pend_s.pop_front()); sb.push_back(pend_e.pop_front()); cyc();
      got = observe(); want = sb.pop_front(); n_cmp++;
      if (got !== want) begin
        n_fail++; $display("FAIL p2_wins[%0d]: got %s, expected %s", i, fmt(got), fmt(want));
      end
      i++;
    end
  endtask

  // Restart into PLAY, then drop reset_n between clock edges.
  task automatic test_async_reset();
    out_t got, want;
    apply(stim(1, 0, 0, 0)); cyc();
    apply(stim(0, 1, 0, 0)); cyc(); cyc();
    apply(stim(0, 0, 0, 0)); cyc();
    n_cmp++;
    if (ball_enable !== 1'b1) begin
      n_fail++; $display("FAIL async_pre_play: ball_enable got %b, expected 1", ball_enable);
    end
    #3 reset_n = 1'b0;
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    #1;
    got = observe(); want = sb.pop_front(); n_cmp++;
    if (got !== want) begin
      n_fail++; $display("FAIL async_reset: got %s, expected %s", fmt(got), fmt(want));
    end
    got = observe0(); want = sb.pop_front(); n_cmp++;
    if (got !== want) begin
      n_fail++; $display("FAIL async_reset_d0: got %s, expected %s", fmt(got), fmt(want));
    end
    cyc();
  endtask

  // SERVE_DELAY=0 instance: SERVE lasts exactly one cycle.
  task automatic test_serve_delay0();
    out_t got, want;
    int   i = 0;
    #3 reset_n = 1'b1;
    add(stim(0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0));
    add(stim(1, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0));
    add(stim(0, 0, 0, 0), mk(0, 0, 1, 0, 0, 0, 0));
    add(stim(0, 0, 0, 1), mk(0, 1, 0, 0, 0, 0, 0));
    add(stim(0, 0, 0, 0), mk(0, 1, 1, 0, 0, 0, 0));
    while (pend_s.size() != 0) begin
      apply(pend_s.pop_front()); sb.push_back(pend_e.pop_front()); cyc();
      got = observe0(); want = sb.pop_front(); n_cmp++;
      if (got !== want) begin
        n_fail++; $display("FAIL serve_delay0[%0d]: got %s, expected %s", i, fmt(got), fmt(want));
      end
      i++;
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_point_p2();
    test_both_points();
    test_game_over();
    test_p2_wins();
    test_async_reset();
    test_serve_delay0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
